// File: rtl/pixel_plot_writer.sv
// Pixel plot writer: queues range-checked plot requests in a 4-entry FIFO and
// streams them to a 160x120 framebuffer, with a drain-then-fill clear-screen mode.
module pixel_plot_writer (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  iX,
    input  logic [6:0]  iY,
    input  logic [8:0]  iColour,
    input  logic        iPlot,
    input  logic        iClear,
    input  logic [8:0]  iClearColour,
    output logic        oReady,
    output logic [14:0] oWrAddr,
    output logic [8:0]  oWrData,
    output logic        oWrEn,
    output logic        oClearDone,
    output logic [7:0]  oDropCount
);

    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  DRAIN = 2'd1;
    localparam logic [1:0]  CLEAR = 2'd2;
    localparam logic [1:0]  DONE  = 2'd3;

    localparam logic [14:0] LAST_ADDR = 15'd19199;

    logic [1:0]  state;
    logic [23:0] fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic [14:0] clr_addr;
    logic [8:0]  clr_colour;

    logic        in_range;
    logic [14:0] plot_addr;
    logic        accept;
    logic        push;
    logic        drop;
    logic        pop;

    // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
    always_comb begin
        in_range   = (iX <= 8'd159) && (iY <= 7'd119);
        plot_addr  = 15'(iY) * 15'd160 + 15'(iX);
        oReady     = (count != 3'd4) && (state == IDLE);
        accept     = iPlot && oReady;
        push       = accept && in_range;
        drop       = accept && !in_range;
        pop        = (count != 3'd0) && ((state == IDLE) || (state == DRAIN));
        oClearDone = (state == DONE);
    end

    // NOTE: the FIFO storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= {plot_addr, iColour};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clr_addr   <= 15'd0;
            clr_colour <= 9'd0;
            oWrEn      <= 1'b0;
            oWrAddr    <= 15'd0;
            oWrData    <= 9'd0;
            oDropCount <= 8'd0;
        end else begin
            oWrEn <= 1'b0;
            // pop is never true in CLEAR, so at most one write source per cycle
            if (pop) begin
                oWrEn              <= 1'b1;
                {oWrAddr, oWrData} <= fifo_mem[rd_ptr];
            end else if (state == CLEAR) begin
                oWrEn   <= 1'b1;
                oWrAddr <= clr_addr;
                oWrData <= clr_colour;
            end

            if (drop && (oDropCount != 8'hFF))
                oDropCount <= oDropCount + 8'd1;

            case (state)
                IDLE: begin
                    if (iClear) begin
                        state      <= DRAIN;
                        clr_colour <= iClearColour;
                    end
                end
                DRAIN: begin
                    if (count == 3'd0)
                        state <= CLEAR;
                end
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        clr_addr <= 15'd0;
                        state    <= DONE;
                    end else begin
                        clr_addr <= clr_addr + 15'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_plot_writer.sv
// Directed bench for pixel_plot_writer: table-driven single plots plus
// hand-written sequences for saturation, clear, back-to-back and reset cases.
module tb_pixel_plot_writer;

    logic        clock;
    logic        reset;
    logic [7:0]  iX;
    logic [6:0]  iY;
    logic [8:0]  iColour;
    logic        iPlot;
    logic        iClear;
    logic [8:0]  iClearColour;
    logic        oReady;
    logic [14:0] oWrAddr;
    logic [8:0]  oWrData;
    logic        oWrEn;
    logic        oClearDone;
    logic [7:0]  oDropCount;

    int checks;
    int errors;

    pixel_plot_writer dut (
        .clock        (clock),
        .reset        (reset),
        .iX           (iX),
        .iY           (iY),
        .iColour      (iColour),
        .iPlot        (iPlot),
        .iClear       (iClear),
        .iClearColour (iClearColour),
        .oReady       (oReady),
        .oWrAddr      (oWrAddr),
        .oWrData      (oWrData),
        .oWrEn        (oWrEn),
        .oClearDone   (oClearDone),
        .oDropCount   (oDropCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [14:0] a;
        logic [8:0]  d;
    } wr_t;

    wr_t log_q[$];
    int  done_pulses;

    always @(negedge clock) begin
        if (oWrEn)
            log_q.push_back({oWrAddr, oWrData});
        if (oClearDone)
            done_pulses++;
    end

    typedef struct {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [8:0]  colour;
        logic        exp_wr;
        logic [14:0] exp_addr;
        logic [8:0]  exp_data;
        logic [7:0]  exp_drop;
    } vec_t;

    typedef struct {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [8:0]  colour;
        logic [14:0] exp_addr;
    } b2b_t;

    vec_t vecs[8];
    b2b_t b2b[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int  bad;
        int  first_bad;
        int  pulses_before;
        bit  seen;

        checks = 0;
        errors = 0;
        done_pulses = 0;

        //             x      y      colour  wr    addr      data    drop
        vecs[0] = '{8'd5,   7'd2,   9'h1AB, 1'b1, 15'd325,   9'h1AB, 8'd0};
        vecs[1] = '{8'd160, 7'd0,   9'h0AA, 1'b0, 15'd325,   9'h1AB, 8'd1};
        vecs[2] = '{8'd0,   7'd0,   9'h001, 1'b1, 15'd0,     9'h001, 8'd1};
        vecs[3] = '{8'd0,   7'd120, 9'h0AA, 1'b0, 15'd0,     9'h001, 8'd2};
        vecs[4] = '{8'd159, 7'd119, 9'h1FF, 1'b1, 15'd19199, 9'h1FF, 8'd2};
        vecs[5] = '{8'd255, 7'd127, 9'h0AA, 1'b0, 15'd19199, 9'h1FF, 8'd3};
        vecs[6] = '{8'd100, 7'd50,  9'h055, 1'b1, 15'd8100,  9'h055, 8'd3};
        vecs[7] = '{8'd3,   7'd3,   9'h123, 1'b1, 15'd483,   9'h123, 8'd3};

        b2b[0] = '{8'd0,   7'd0,   9'h011, 15'd0};
        b2b[1] = '{8'd159, 7'd119, 9'h022, 15'd19199};
        b2b[2] = '{8'd1,   7'd1,   9'h033, 15'd161};
        b2b[3] = '{8'd20,  7'd10,  9'h044, 15'd1620};
        b2b[4] = '{8'd7,   7'd0,   9'h055, 15'd7};

        reset = 1'b1;
        iX = '0; iY = '0; iColour = '0; iPlot = 1'b0; iClear = 1'b0; iClearColour = '0;

        // Reset state
        #12;
        check("rst_wren",  oWrEn, 0);
        check("rst_done",  oClearDone, 0);
        check("rst_addr",  oWrAddr, 0);
        check("rst_data",  oWrData, 0);
        check("rst_drop",  oDropCount, 0);
        @(negedge clock);
        reset = 1'b0;
        step();
        check("rst_ready", oReady, 1);

        // Single plots, valid and out of range
        for (int i = 0; i < 8; i++) begin
            iX = vecs[i].x; iY = vecs[i].y; iColour = vecs[i].colour; iPlot = 1'b1;
            step();
            iPlot = 1'b0;
            step();
            check($sformatf("vec%0d_wren", i), oWrEn, vecs[i].exp_wr);
            check($sformatf("vec%0d_addr", i), oWrAddr, vecs[i].exp_addr);
            check($sformatf("vec%0d_data", i), oWrData, vecs[i].exp_data);
            check($sformatf("vec%0d_drop", i), oDropCount, vecs[i].exp_drop);
            step();
            check($sformatf("vec%0d_wren_after", i), oWrEn, 0);
        end

        // Drop counter saturation: 260 further invalid plots
        log_q.delete();
        iX = 8'd200; iY = 7'd0; iPlot = 1'b1;
        repeat (251) step();
        check("drop_254", oDropCount, 254);
        repeat (9) step();
        check("drop_sat", oDropCount, 255);
        iPlot = 1'b0;
        step();
        check("drop_no_writes", log_q.size(), 0);

        // Clear with two plots queued; the second plot arrives with iClear
        log_q.delete();
        done_pulses = 0;
        iX = 8'd10; iY = 7'd0; iColour = 9'h0C1; iPlot = 1'b1;
        step();
        iX = 8'd3; iY = 7'd3; iColour = 9'h0C2; iClear = 1'b1; iClearColour = 9'h0F0;
        step();
        iPlot = 1'b0; iClear = 1'b0; iClearColour = 9'h155;
        seen = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (i == 100) begin
                check("clear_busy_ready", oReady, 0);
                iClear = 1'b1; iPlot = 1'b1; iX = 8'd1; iY = 7'd1; iClearColour = 9'h00F;
            end
            step();
            iClear = 1'b0; iPlot = 1'b0;
            if (oClearDone) begin
                seen = 1'b1;
                break;
            end
        end
        check("clear_done_seen", seen, 1);
        step();
        check("clear_done_one_cycle", oClearDone, 0);
        check("clear_ready_after", oReady, 1);
        repeat (5) step();
        check("clear_done_pulses", done_pulses, 1);
        check("clear_log_size", log_q.size(), 19202);
        check("clear_plot0", log_q[0], {15'd10, 9'h0C1});
        check("clear_plot1", log_q[1], {15'd483, 9'h0C2});
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < 19200; i++) begin
            if (log_q[i + 2] !== {15'(i), 9'h0F0}) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        check("clear_seq_bad", bad, 0);
        if (bad != 0) $display("first bad clear index %0d", first_bad);

        // Five back-to-back plots
        log_q.delete();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("b2b%0d_ready", i), oReady, 1);
            iX = b2b[i].x; iY = b2b[i].y; iColour = b2b[i].colour; iPlot = 1'b1;
            step();
        end
        iPlot = 1'b0;
        repeat (3) step();
        check("b2b_count", log_q.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("b2b%0d_write", i), log_q[i], {b2b[i].exp_addr, b2b[i].colour});

        // Reset in the middle of a clear
        iClear = 1'b1; iClearColour = 9'h0F0;
        step();
        iClear = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            step();
            if (oWrEn && oWrAddr == 15'd5000) begin
                seen = 1'b1;
                break;
            end
        end
        check("midclr_reached_5000", seen, 1);
        #1 reset = 1'b1;
        #1;
        check("midclr_wren", oWrEn, 0);
        check("midclr_addr", oWrAddr, 0);
        check("midclr_data", oWrData, 0);
        check("midclr_drop", oDropCount, 0);
        pulses_before = done_pulses;
        @(negedge clock);
        reset = 1'b0;
        step();
        check("midclr_ready", oReady, 1);
        check("midclr_drop_after", oDropCount, 0);
        log_q.delete();
        repeat (100) step();
        check("midclr_no_writes", log_q.size(), 0);
        check("midclr_no_done", done_pulses, pulses_before);

        // Entry pending at reset is discarded
        iX = 8'd1; iY = 7'd0; iColour = 9'h1EE; iPlot = 1'b1;
        step();
        iPlot = 1'b0;
        reset = 1'b1;
        #1;
        check("pending_wren", oWrEn, 0);
        log_q.delete();
        @(negedge clock);
        reset = 1'b0;
        repeat (5) step();
        check("pending_discarded", log_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_plot_writer.md
PIXEL_PLOT_WRITER -- requirements
Module: pixel_plot_writer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port list (name, direction, width, meaning), in this order:
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high reset.
- iX, in, 8: pixel column (valid range 0..159).
- iY, in, 7: pixel row (valid range 0..119).
- iColour, in, 9: pixel colour.
- iPlot, in, 1: plot request; accepted on a clock edge when iPlot=1 and oReady=1.
- iClear, in, 1: clear-screen request.
- iClearColour, in, 9: fill colour for a clear, sampled when the clear is accepted.
- oReady, out, 1: the block can accept a plot.
- oWrAddr, out, 15: framebuffer write address.
- oWrData, out, 9: framebuffer write data.
- oWrEn, out, 1: framebuffer write strobe, one write per cycle.
- oClearDone, out, 1: one-cycle pulse when a clear completes.
- oDropCount, out, 8: count of discarded out-of-range plots, saturating.

Function
REQ-003 The block SHALL contain a 4-entry FIFO of {address[14:0], colour[8:0]} plot entries.
REQ-004 oReady SHALL equal (FIFO not full) AND (state = IDLE).
REQ-005 An accepted plot with iX<=159 and iY<=119 SHALL push address = iX + 160*iY, computed at 15 bits (range 0..19199), together with iColour.
REQ-006 An accepted plot with iX>159 or iY>119 SHALL NOT be pushed, and oDropCount SHALL increment, saturating at 255.
REQ-007 While the FIFO is non-empty and the state is IDLE or DRAIN, the block SHALL pop one entry per cycle into registered outputs oWrAddr, oWrData and oWrEn=1.
- Latency: a plot accepted at edge N into an empty FIFO SHALL be presented with oWrEn=1 from edge N+1 until edge N+2.
- Sustained throughput SHALL be one write per cycle.
REQ-008 When no write is issued in a cycle, oWrEn SHALL be 0 and oWrAddr/oWrData SHALL hold their previous values.
REQ-009 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
- Full FIFO: no push occurs, because oReady=0.
- Empty FIFO: no pop occurs.
REQ-010 FSM states and transitions:
- IDLE -> DRAIN when iClear=1; iClearColour is latched on that edge.
- DRAIN -> CLEAR when the FIFO is empty.
- CLEAR -> DONE after the write to address 19199.
- DONE -> IDLE unconditionally.
REQ-011 In CLEAR the block SHALL write addresses 0..19199 in ascending order, one per cycle, with oWrEn=1 and oWrData = the latched clear colour (19200 writes in total).
REQ-012 oClearDone SHALL be 1 only in state DONE (exactly one cycle).
REQ-013 iClear SHALL be ignored outside IDLE; iPlot SHALL be ignored while oReady=0.
REQ-014 When iPlot and iClear are both 1 in IDLE with oReady=1, the plot SHALL be accepted and written during DRAIN, before the clear begins.
REQ-015 The FIFO pop, the clear-address counter and the DRAIN exit SHALL be mutually exclusive per cycle, so that at most one write is issued per cycle.

Reset
REQ-016 Reset SHALL asynchronously force the following values, effective immediately including mid-clear or mid-drain:
- state = IDLE, FIFO empty, clear counter = 0, oDropCount = 0.
- oWrEn = 0, oClearDone = 0, oWrAddr = 0, oWrData = 0.
- oReady = 1 from the first edge after reset deasserts.
REQ-017 Entries pending at reset SHALL be discarded and never written.

Verification
REQ-018 Single plot: iX=5, iY=2, iColour=0x1AB, iPlot pulsed at edge N -> oWrEn=1, oWrAddr=325, oWrData=0x1AB during cycle N+1..N+2; oWrEn=0 afterwards.
REQ-019 Back-pressure: hold the write path busy (clear running) -> oReady=0; then, in IDLE, issue 4 back-to-back plots followed by a 5th -> all 5 are written in order, oWrAddr(0,0)=0 and (159,119)=19199, with no loss or duplication.
REQ-020 Range check: plots (160,0), (0,120) and (255,127) -> no oWrEn, oDropCount=3; issue 260 invalid plots -> oDropCount=255.
REQ-021 Clear: iClear=1 with iClearColour=0x0F0 and 2 plots queued -> the 2 plot writes come first, then 19200 writes at addresses 0..19199 with data 0x0F0, then oClearDone=1 for one cycle, then oReady=1.
REQ-022 Simultaneous and ignored requests: iPlot(3,3) and iClear in the same IDLE cycle -> address 483 is written before address 0; iClear pulsed during CLEAR -> exactly one oClearDone.
REQ-023 Reset mid-clear: assert reset at clear address 5000 -> oWrEn=0 immediately; after release, oReady=1, oDropCount=0, and no oClearDone pulse.
